// File: rtl/cart_fetch.sv
// Cartridge ROM responder: one-word cache in front of a req/ack word memory; hits return in 1 clock, misses 1 clock after ack.
// Stalls by holding mem_req until ack; accepts during a fetch park in a depth-1 pending slot (newest wins).
module cart_fetch #(
   parameter int                MEM_AW = 25,
   parameter logic [MEM_AW-1:0] BASE   = '0
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              loading,
   input  logic              pclk1,
   input  logic              pclk0,
   input  logic              cart_sel,
   input  logic [18:0]       cart_addr,
   input  logic [18:0]       cart_mask,
   output logic [7:0]        cart_out,
   output logic              mem_req,
   output logic [MEM_AW-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [15:0]       mem_rdata,
   output logic              fetch_late
);

   typedef enum logic {IDLE, REQ} state_t;

   state_t      state, state_nxt;
   logic [17:0] tag;
   logic        valid;
   logic [15:0] word;
   logic [18:0] cur;
   logic        pend;
   logic [18:0] pend_addr;
   logic        reeval;
   logic        cur_new;

   logic [18:0] ea;
   logic [18:0] eval_addr;
   logic        acc;
   logic        eval;
   logic        hit;
   logic        launch;
   logic        done;

   assign ea      = cart_addr & cart_mask;
   assign acc     = pclk1 && cart_sel && !loading;
   assign mem_req = (state == REQ);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // A fresh accept in the re-evaluation cycle supersedes the parked address.
   always_comb begin
      state_nxt = state;
      eval_addr = acc ? ea : pend_addr;
      eval      = 1'b0;
      hit       = 1'b0;
      launch    = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            eval   = !loading && (acc || reeval);
            hit    = eval && valid && (tag == eval_addr[18:1]);
            launch = eval && !hit;
            if (launch) state_nxt = REQ;
         end
         REQ: begin
            done = mem_ack;
            if (done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         tag        <= '0;
         valid      <= 1'b0;
         word       <= '0;
         cur        <= '0;
         pend       <= 1'b0;
         pend_addr  <= '0;
         reeval     <= 1'b0;
         cur_new    <= 1'b0;
         cart_out   <= '0;
         mem_addr   <= '0;
         fetch_late <= 1'b0;
      end else begin
         reeval     <= 1'b0;
         fetch_late <= pclk0 && (state == REQ) && cur_new;

         if (launch) begin
            cur      <= eval_addr;
            mem_addr <= BASE + {{(MEM_AW-19){1'b0}}, eval_addr[18:1], 1'b0};
            cur_new  <= 1'b1;
         end else if (pclk1) begin
            cur_new  <= 1'b0;
         end

         if (hit)
            cart_out <= eval_addr[0] ? word[15:8] : word[7:0];

         // Data returned while a download is in progress is stale; drop it.
         if (done && !loading) begin
            word     <= mem_rdata;
            tag      <= cur[18:1];
            cart_out <= cur[0] ? mem_rdata[15:8] : mem_rdata[7:0];
         end

         if (loading) begin
            valid <= 1'b0;
            pend  <= 1'b0;
         end else if (done) begin
            valid  <= 1'b1;
            pend   <= 1'b0;
            reeval <= pend || acc;
            if (acc) pend_addr <= ea;
         end else if ((state == REQ) && acc) begin
            pend      <= 1'b1;
            pend_addr <= ea;
         end
      end
   end

endmodule

// File: tb/tb_cart_fetch.sv
// Bench for cart_fetch: directed scenarios followed by random accesses checked against a cache/memory reference model.
module tb_cart_fetch;

   localparam logic [24:0] BASE = 25'h100000;

   logic        clk_sys   = 1'b0;
   logic        reset_n   = 1'b0;
   logic        loading   = 1'b0;
   logic        pclk1     = 1'b0;
   logic        pclk0     = 1'b0;
   logic        cart_sel  = 1'b0;
   logic [18:0] cart_addr = '0;
   logic [18:0] cart_mask = 19'h7FFFF;
   logic        mem_ack   = 1'b0;
   logic [15:0] mem_rdata = '0;
   logic [7:0]  cart_out;
   logic        mem_req;
   logic [24:0] mem_addr;
   logic        fetch_late;

   int n_cmp = 0;
   int n_bad = 0;

   cart_fetch #(.MEM_AW(25), .BASE(BASE)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .loading(loading),
      .pclk1(pclk1), .pclk0(pclk0), .cart_sel(cart_sel),
      .cart_addr(cart_addr), .cart_mask(cart_mask), .cart_out(cart_out),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .fetch_late(fetch_late)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(negedge clk_sys);
   endtask

   // Present one bus cycle; returns at the falling edge after the accepting edge.
   task automatic bus(input logic [18:0] a, input logic [18:0] m, input logic sel);
      cart_addr = a;
      cart_mask = m;
      cart_sel  = sel;
      pclk1     = 1'b1;
      step;
      pclk1     = 1'b0;
      cart_sel  = 1'b0;
   endtask

   task automatic ack(input logic [15:0] d);
      mem_ack   = 1'b1;
      mem_rdata = d;
      step;
      mem_ack   = 1'b0;
   endtask

   function automatic logic [15:0] memw(input logic [17:0] w);
      logic [31:0] p;
      p = {14'd0, w} * 32'h9E37 + 32'h5A5;
      return p[15:0] ^ {w[17:16], 14'h1A5};
   endfunction

   function automatic logic [7:0] pick(input logic [15:0] w, input logic odd);
      return odd ? w[15:8] : w[7:0];
   endfunction

   // Reference model state
   logic        m_valid;
   logic [17:0] m_tag;
   logic [15:0] m_word;
   logic [7:0]  m_out;

   initial begin
      logic [18:0] a, m, ea;
      logic [15:0] d;
      int r;

      step; step;
      chk("rst_cart_out", 32'(cart_out), 0);
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_fetch_late", 32'(fetch_late), 0);
      reset_n = 1'b1;
      step;

      // Cold miss, ack three clocks after the accept
      bus(19'h00000, 19'h7FFFF, 1'b1);
      chk("miss_req", 32'(mem_req), 1);
      chk("miss_addr", 32'(mem_addr), 32'(BASE));
      step; step;
      chk("miss_req_hold", 32'(mem_req), 1);
      chk("miss_addr_hold", 32'(mem_addr), 32'(BASE));
      ack(16'hBEEF);
      chk("miss_req_drop", 32'(mem_req), 0);
      chk("miss_byte", 32'(cart_out), 'hEF);
      step;
      chk("miss_no_rereq", 32'(mem_req), 0);

      // Odd byte of the cached word
      bus(19'h00001, 19'h7FFFF, 1'b1);
      chk("hit_no_req", 32'(mem_req), 0);
      chk("hit_byte", 32'(cart_out), 'hBE);

      // Masked address: 0x14003 & 0x03FFF = 0x00003, word at byte 2
      bus(19'h14003, 19'h03FFF, 1'b1);
      chk("mask_req", 32'(mem_req), 1);
      chk("mask_addr", 32'(mem_addr), 32'(BASE + 25'h2));
      step;
      ack(16'h1234);
      chk("mask_byte", 32'(cart_out), 'h12);
      step;

      // Two accepts during a fetch: only the newest is followed up
      bus(19'h00100, 19'h7FFFF, 1'b1);
      chk("pend_req0", 32'(mem_req), 1);
      chk("pend_addr0", 32'(mem_addr), 32'(BASE + 25'h100));
      bus(19'h00200, 19'h7FFFF, 1'b1);
      chk("pend_addr_hold", 32'(mem_addr), 32'(BASE + 25'h100));
      bus(19'h00300, 19'h7FFFF, 1'b1);
      ack(16'hC0DE);
      chk("pend_byte0", 32'(cart_out), 'hDE);
      chk("pend_gap", 32'(mem_req), 0);
      step;
      chk("pend_req1", 32'(mem_req), 1);
      chk("pend_addr1", 32'(mem_addr), 32'(BASE + 25'h300));
      ack(16'h7788);
      chk("pend_byte1", 32'(cart_out), 'h88);
      step;
      chk("pend_no_third0", 32'(mem_req), 0);
      step;
      chk("pend_no_third1", 32'(mem_req), 0);

      // pclk0 while the fetch for this bus cycle is still outstanding
      bus(19'h00401, 19'h7FFFF, 1'b1);
      pclk0 = 1'b1;
      step;
      pclk0 = 1'b0;
      chk("late_pulse", 32'(fetch_late), 1);
      chk("late_out_hold", 32'(cart_out), 'h88);
      step;
      chk("late_one_clk", 32'(fetch_late), 0);
      chk("late_req_hold", 32'(mem_req), 1);
      ack(16'h4321);
      chk("late_byte", 32'(cart_out), 'h43);
      bus(19'h00400, 19'h7FFFF, 1'b1);
      pclk0 = 1'b1;
      step;
      pclk0 = 1'b0;
      chk("hit_byte2", 32'(cart_out), 'h21);
      chk("hit_not_late", 32'(fetch_late), 0);

      // Download begins mid-fetch: the ack is dropped and the cache invalidated
      bus(19'h00500, 19'h7FFFF, 1'b1);
      chk("load_req", 32'(mem_req), 1);
      loading = 1'b1;
      step; step;
      ack(16'hAAAA);
      chk("load_drop_out", 32'(cart_out), 'h21);
      chk("load_req_drop", 32'(mem_req), 0);
      loading = 1'b0;
      step;
      bus(19'h00500, 19'h7FFFF, 1'b1);
      chk("load_refetch", 32'(mem_req), 1);
      ack(16'h9C3D);
      chk("load_byte", 32'(cart_out), 'h3D);
      step;

      // Random accesses against the reference model
      loading = 1'b1;
      step;
      loading = 1'b0;
      step;
      m_valid = 1'b0;
      m_tag   = '0;
      m_word  = '0;
      m_out   = 8'h3D;
      for (int i = 0; i < 150; i++) begin
         r = $urandom_range(0, 9);
         a = 19'($urandom);
         m = ($urandom_range(0, 1) == 1) ? 19'h0000F : 19'h0003F;
         ea = a & m;
         if (r == 0) begin
            bus(a, m, 1'b0);
            chk("rnd_nosel_req", 32'(mem_req), 0);
            chk("rnd_nosel_out", 32'(cart_out), 32'(m_out));
         end else if (r == 1) begin
            loading = 1'b1;
            step;
            loading = 1'b0;
            m_valid = 1'b0;
         end else begin
            bus(a, m, 1'b1);
            if (m_valid && m_tag == ea[18:1]) begin
               m_out = pick(m_word, ea[0]);
               chk("rnd_hit_req", 32'(mem_req), 0);
               chk("rnd_hit_out", 32'(cart_out), 32'(m_out));
            end else begin
               chk("rnd_miss_req", 32'(mem_req), 1);
               chk("rnd_miss_addr", 32'(mem_addr), 32'(BASE + {6'd0, ea[18:1], 1'b0}));
               repeat ($urandom_range(0, 3)) step;
               d = memw(ea[18:1]);
               ack(d);
               m_valid = 1'b1;
               m_tag   = ea[18:1];
               m_word  = d;
               m_out   = pick(d, ea[0]);
               chk("rnd_miss_out", 32'(cart_out), 32'(m_out));
               chk("rnd_miss_drop", 32'(mem_req), 0);
            end
         end
         step;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
